// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: writeback requester, clear-control and register-file write bus of gpr_wb_arbiter
interface gpr_wb_arbiter_if;
  logic        A_Valid;
  logic [4:0]  A_RD;
  logic [31:0] A_WData;
  logic        A_Ready;
  logic        B_Valid;
  logic [4:0]  B_RD;
  logic [31:0] B_WData;
  logic        B_Ready;
  logic        Clear;
  logic        Busy;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [31:0] WData;
  modport master (
    output A_Valid, A_RD, A_WData, B_Valid, B_RD, B_WData, Clear,
    input  A_Ready, B_Ready, Busy, RegWrite, RD, WData
  );
  modport slave (
    input  A_Valid, A_RD, A_WData, B_Valid, B_RD, B_WData, Clear,
    output A_Ready, B_Ready, Busy, RegWrite, RD, WData
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin writeback arbiter with a register-file clear sequencer.
// Define GPR_ARB_R0_FILTER_EN to suppress register-file writes to index 0 from requesters.
module gpr_wb_arbiter #(
  parameter int NREG = 32
) (
  input logic             Clk,
  input logic             Reset_n,
  gpr_wb_arbiter_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        last_b;
  logic        open;
  logic        grant_a;
  logic        grant_b;
  logic        fwd;
  logic [4:0]  sel_rd;
  logic [31:0] sel_wdata;
  // Busy also covers the cycle after the last clear write is issued, so grants wait for Busy=0
  always_comb begin
    open      = Reset_n && state == IDLE && !bus.Busy && !bus.Clear;
    grant_a   = open && bus.A_Valid && (!bus.B_Valid || last_b);
    grant_b   = open && bus.B_Valid && (!bus.A_Valid || !last_b);
    sel_rd    = grant_a ? bus.A_RD : bus.B_RD;
    sel_wdata = grant_a ? bus.A_WData : bus.B_WData;
`ifdef GPR_ARB_R0_FILTER_EN
    fwd       = (grant_a || grant_b) && sel_rd != 5'd0;
`else
    fwd       = grant_a || grant_b;
`endif
  end
  assign bus.A_Ready = grant_a;
  assign bus.B_Ready = grant_b;
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      last_b       <= 1'b1;
      bus.RegWrite <= 1'b0;
      bus.RD       <= 5'd0;
      bus.WData    <= 32'd0;
      bus.Busy     <= 1'b0;
    end else begin
      bus.RegWrite <= 1'b0;
      if (grant_a) last_b <= 1'b0;
      else if (grant_b) last_b <= 1'b1;
      if (state == CLEAR) begin
        bus.RegWrite <= 1'b1;
        bus.RD       <= cnt;
        bus.WData    <= 32'd0;
        bus.Busy     <= 1'b1;
        cnt          <= cnt == 5'(NREG - 1) ? 5'd0 : cnt + 5'd1;
        state        <= cnt == 5'(NREG - 1) ? IDLE : CLEAR;
      end else begin
        bus.Busy <= 1'b0;
        if (bus.Clear && !bus.Busy) begin
          state <= CLEAR;
          cnt   <= 5'd0;
        end else if (fwd) begin
          bus.RegWrite <= 1'b1;
          bus.RD       <= sel_rd;
          bus.WData    <= sel_wdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed checks of grants, writeback timing, clear sequence and reset abort.
module tb_gpr_wb_arbiter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  logic done = 1'b0;
  gpr_wb_arbiter_if bus();
  gpr_wb_arbiter #(.NREG(32)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(string tag, logic ok);
    vectors++;
    if (!ok) begin
      errs++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #100000;
    if (!done) begin
      $error("FAIL timeout: test did not complete");
      $finish;
    end
  end
  initial begin
    bus.A_Valid = 0; bus.A_RD = 0; bus.A_WData = 0;
    bus.B_Valid = 0; bus.B_RD = 0; bus.B_WData = 0;
    bus.Clear = 0;
    tick(); tick();
    chk("rst_regwrite", bus.RegWrite === 1'b0);
    chk("rst_rd", bus.RD === 5'd0);
    chk("rst_wdata", bus.WData === 32'd0);
    chk("rst_busy", bus.Busy === 1'b0);
    bus.A_Valid = 1; #1;
    chk("rst_a_ready", bus.A_Ready === 1'b0);
    bus.A_Valid = 0;
    Reset_n = 1;
    tick();
    bus.A_Valid = 1; bus.A_RD = 3; bus.A_WData = 32'h1234; #1;
    chk("a_only_ready", bus.A_Ready === 1'b1);
    chk("a_only_b_ready", bus.B_Ready === 1'b0);
    tick();
    bus.A_Valid = 0;
    chk("a_wr", bus.RegWrite === 1'b1);
    chk("a_rd", bus.RD === 5'd3);
    chk("a_wdata", bus.WData === 32'h1234);
    #1;
    chk("a_idle_ready", bus.A_Ready === 1'b0);
    tick();
    chk("a_wr_drop", bus.RegWrite === 1'b0);
    chk("a_rd_hold", bus.RD === 5'd3);
    chk("a_wdata_hold", bus.WData === 32'h1234);
    bus.B_Valid = 1; bus.B_RD = 7; bus.B_WData = 32'hBEEF; #1;
    chk("b_only_ready", bus.B_Ready === 1'b1);
    chk("b_only_a_ready", bus.A_Ready === 1'b0);
    tick();
    bus.B_Valid = 0;
    chk("b_wr", bus.RegWrite === 1'b1);
    chk("b_rd", bus.RD === 5'd7);
    chk("b_wdata", bus.WData === 32'hBEEF);
    bus.A_Valid = 1; bus.A_RD = 1; bus.A_WData = 32'hA;
    bus.B_Valid = 1; bus.B_RD = 2; bus.B_WData = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_a_ready", bus.A_Ready === (i % 2 == 0));
      chk("tie_b_ready", bus.B_Ready === (i % 2 == 1));
      tick();
      chk("tie_wr", bus.RegWrite === 1'b1);
      chk("tie_rd", bus.RD === ((i % 2 == 0) ? 5'd1 : 5'd2));
      chk("tie_wdata", bus.WData === ((i % 2 == 0) ? 32'hA : 32'hB));
    end
    bus.A_Valid = 0; bus.B_Valid = 0;
    tick();
    chk("tie_end_wr", bus.RegWrite === 1'b0);
    bus.Clear = 1; bus.A_Valid = 1; bus.A_RD = 9; bus.A_WData = 32'h99; #1;
    chk("clr_a_blocked", bus.A_Ready === 1'b0);
    tick();
    bus.Clear = 0; #1;
    chk("clr_enter_a_ready", bus.A_Ready === 1'b0);
    chk("clr_enter_busy", bus.Busy === 1'b0);
    for (int k = 0; k < 32; k++) begin
      tick();
      bus.Clear = (k == 5); #1;
      chk("clr_busy", bus.Busy === 1'b1);
      chk("clr_wr", bus.RegWrite === 1'b1);
      chk("clr_rd", bus.RD === 5'(k));
      chk("clr_wdata", bus.WData === 32'd0);
      chk("clr_a_ready", bus.A_Ready === 1'b0);
    end
    bus.Clear = 0;
    tick();
    chk("clr_done_busy", bus.Busy === 1'b0);
    chk("clr_done_wr", bus.RegWrite === 1'b0);
    chk("clr_done_rd", bus.RD === 5'd31);
    chk("clr_done_a_ready", bus.A_Ready === 1'b1);
    tick();
    bus.A_Valid = 0;
    chk("post_clr_wr", bus.RegWrite === 1'b1);
    chk("post_clr_rd", bus.RD === 5'd9);
    chk("post_clr_wdata", bus.WData === 32'h99);
    bus.Clear = 1;
    tick();
    bus.Clear = 0;
    for (int k = 0; k < 11; k++) tick();
    chk("abort_rd10", bus.RD === 5'd10);
    chk("abort_busy_before", bus.Busy === 1'b1);
    Reset_n = 0;
    tick();
    chk("abort_wr", bus.RegWrite === 1'b0);
    chk("abort_busy", bus.Busy === 1'b0);
    chk("abort_rd", bus.RD === 5'd0);
    Reset_n = 1;
    tick();
    chk("abort_no_resume_wr", bus.RegWrite === 1'b0);
    chk("abort_no_resume_busy", bus.Busy === 1'b0);
    bus.B_Valid = 1; bus.B_RD = 0; bus.B_WData = 32'hFFFF; #1;
    chk("r0_b_ready", bus.B_Ready === 1'b1);
    tick();
    bus.B_Valid = 0;
`ifdef GPR_ARB_R0_FILTER_EN
    chk("r0_wr", bus.RegWrite === 1'b0);
`else
    chk("r0_wr", bus.RegWrite === 1'b1);
    chk("r0_rd", bus.RD === 5'd0);
    chk("r0_wdata", bus.WData === 32'hFFFF);
`endif
    bus.A_Valid = 1; bus.A_RD = 4; bus.B_Valid = 1; bus.B_RD = 5; #1;
    chk("r0_tie_a_ready", bus.A_Ready === 1'b1);
    chk("r0_tie_b_ready", bus.B_Ready === 1'b0);
    tick();
    bus.A_Valid = 0; bus.B_Valid = 0;
    chk("r0_tie_rd", bus.RD === 5'd4);
    done = 1'b1;
    if (errs != 0) $error("FAIL %0d miscompares detected", errs);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter: NREG, default 32, number of registers walked by the clear sequence (1..32).
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Reset_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-004 A_Valid  input  1  requester A (ALU writeback) holds a write.
REQ-005 A_RD  input  5  requester A destination register.
REQ-006 A_WData  input  32  requester A write data.
REQ-007 A_Ready  output  1  A transfer accepted this cycle when A_Valid&&A_Ready.
REQ-008 B_Valid  input  1  requester B (load writeback) holds a write.
REQ-009 B_RD  input  5  requester B destination register.
REQ-010 B_WData  input  32  requester B write data.
REQ-011 B_Ready  output  1  B transfer accepted this cycle when B_Valid&&B_Ready.
REQ-012 Clear  input  1  request to zero registers 0..NREG-1.
REQ-013 Busy  output  1  clear sequence in progress.
REQ-014 RegWrite  output  1  write strobe to register file, registered.
REQ-015 RD  output  5  register file write index, registered.
REQ-016 WData  output  32  register file write data, registered.

Function
REQ-017 FSM states SHALL be IDLE and CLEAR.
REQ-018 In IDLE with Clear=0, SHALL grant at most one requester per cycle; Ready is combinational from Valid inputs, state and round-robin pointer.
REQ-019 Only one Valid high -> that requester's Ready=1 the same cycle; the other's Ready=0.
REQ-020 Both Valid high -> grant the requester not granted last; pointer records the last granted requester; pointer resets to B so A wins the first tie.
REQ-021 Pointer SHALL update only on a completed handshake.
REQ-022 Handshake at edge N -> RegWrite=1 with RD/WData of the granted transfer in the cycle after edge N, for exactly one cycle.
REQ-023 No handshake -> RegWrite=0 next cycle; RD/WData hold their previous values.
REQ-024 Ready SHALL never be asserted while the corresponding Valid is low.
REQ-025 Clear=1 sampled in IDLE -> A_Ready=B_Ready=0 that cycle; next state CLEAR with counter=0.
REQ-026 Clear SHALL take priority over simultaneous A/B requests; blocked requests stay pending and keep Valid and data stable.
REQ-027 In CLEAR, registered outputs SHALL issue RegWrite=1, RD=counter, WData=0 on NREG consecutive cycles, counter 0..NREG-1.
REQ-028 Busy=1 from the first to the last clear write cycle inclusive; A_Ready=B_Ready=0 throughout CLEAR.
REQ-029 After the write of index NREG-1, SHALL return to IDLE; requesters may be granted in the first cycle Busy=0.
REQ-030 Clear asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-031 Counter SHALL be 5 bits; NREG=32 SHALL end at 31 without wrap to 0.

Reset
REQ-032 Reset_n=0 at an edge -> state IDLE, counter 0, pointer=B, RegWrite=0, RD=0, WData=0, Busy=0.
REQ-033 Ready outputs SHALL be 0 while Reset_n=0.
REQ-034 Reset during CLEAR SHALL abort the sequence; no further clear writes are issued.

Configuration
REQ-035 Macro GPR_ARB_R0_FILTER_EN defined: handshakes with RD==0 complete normally and update the pointer, but the following cycle shows RegWrite=0; clear writes to index 0 are unaffected.
REQ-036 Macro undefined: writes to RD==0 are forwarded like any other index.

Verification
REQ-037 Reset, then A_Valid=1, A_RD=3, A_WData=0x1234 for one cycle -> A_Ready=1; next cycle RegWrite=1, RD=3, WData=0x1234; the cycle after that RegWrite=0.
REQ-038 A and B valid continuously for 4 cycles after reset -> grants A,B,A,B; RegWrite high 4 consecutive cycles with alternating RDs.
REQ-039 Clear pulse with A_Valid=1 in the same cycle, NREG=32 -> A_Ready=0; Busy high for 32 cycles; RD 0..31 with WData=0; A granted in the first cycle Busy=0.
REQ-040 Reset_n=0 for one cycle at clear write index 10 -> next cycle RegWrite=0, Busy=0, state IDLE.
REQ-041 With GPR_ARB_R0_FILTER_EN, B_Valid=1, B_RD=0, B_WData=0xFFFF -> B_Ready=1, next cycle RegWrite=0; then with A and B both valid, A is granted first.
REQ-042 Clear re-asserted at clear write index 5 -> sequence still ends after index 31; Busy falls exactly 32 cycles after it rose.
